mainfsm: RTL and testbench

Main control state machine for the multicycle ARM core. It sequences the shared datapath (memory port, ALU, register file, instruction register and PC) across the cycles of each instruction. It drives the raw RegW/MemW/Branch/NextPC strobes; the condition-check/flag logic downstream gates them with CondEx. All control outputs are Moore outputs decoded from the registered state.

---
 rtl/mainfsm.sv | 144 ++++++++++++++
 tb/tb_mainfsm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - main control FSM for the multicycle ARM core
// Moore machine: every control output is decoded from the registered state only.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic [1:0] ResultSrc,
    output logic       InstrDone,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_unused;
    assign w_unused = &{1'b0, Funct[4:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   w_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWR:    w_next = S_FETCH;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            // Only reset leaves UNKNOWN; codes 11-15 fall to FETCH via the default.
            S_UNKNOWN:  w_next = S_UNKNOWN;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 1'b0;
        ResultSrc = 2'b00;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                MemW      = 1'b1;
                AdrSrc    = 1'b1;
                InstrDone = 1'b1;
            end
            S_EXECUTER: begin
                ALUOp = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                Branch    = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                InstrDone = 1'b1;
            end
            S_UNKNOWN: begin
                Illegal = 1'b1;
            end
            default: begin
                Illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - table-driven self-checking bench for mainfsm
module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, InstrDone, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

    always #5 clk = ~clk;

    mainfsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ResultSrc(ResultSrc), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    // {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,InstrDone,Illegal}
    localparam logic [14:0] E_FETCH  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,1'b0,2'b10,1'b0,1'b0};
    localparam logic [14:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,1'b0,2'b10,1'b0,1'b0};
    localparam logic [14:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b0,2'b00,1'b0,1'b0};
    localparam logic [14:0] E_MEMRD  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam logic [14:0] E_MEMWB  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b1,1'b0};
    localparam logic [14:0] E_MEMWR  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
    localparam logic [14:0] E_EXR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b0,1'b0};
    localparam logic [14:0] E_EXI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,2'b00,1'b0,1'b0};
    localparam logic [14:0] E_ALUWB  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
    localparam logic [14:0] E_BR     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,1'b0,2'b10,1'b1,1'b0};
    localparam logic [14:0] E_UNK    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b1};

    typedef struct {
        logic        rst_n;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   done_at[$];

    function automatic logic [14:0] outs();
        return {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUSrcB,
                ALUOp, ResultSrc, InstrDone, Illegal};
    endfunction

    function automatic void add(input logic r, input logic [1:0] o, input logic [5:0] f,
                                input logic [14:0] e, input string n);
        vec_t v;
        v.rst_n = r; v.op = o; v.funct = f; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] o, input logic [5:0] f,
                        input logic [14:0] e, input string n);
        reset = r; Op = o; Funct = f;
        @(posedge clk);
        #1;
        cycle++;
        if (InstrDone === 1'b1) done_at.push_back(cycle);
        check(n, {17'd0, outs()}, {17'd0, e});
    endtask

    initial begin
        reset = 1'b0; Op = 2'b01; Funct = 6'd0;
        // Reset hold with Op=01, then release
        add(0, 2'b01, 6'b000000, E_FETCH,  "rst_hold0");
        add(0, 2'b01, 6'b000000, E_FETCH,  "rst_hold1");
        add(0, 2'b01, 6'b000000, E_FETCH,  "rst_hold2");
        add(1, 2'b11, 6'b111111, E_DECODE, "rst_release_decode");
        // Data-processing register
        add(1, 2'b00, 6'b001000, E_EXR,    "dpr_executer");
        add(1, 2'b11, 6'b101111, E_ALUWB,  "dpr_aluwb");
        add(1, 2'b11, 6'b111111, E_FETCH,  "dpr_fetch");
        add(1, 2'b10, 6'b000000, E_DECODE, "dpi_decode");
        // Data-processing immediate
        add(1, 2'b00, 6'b101001, E_EXI,    "dpi_executei");
        add(1, 2'b01, 6'b000000, E_ALUWB,  "dpi_aluwb");
        add(1, 2'b10, 6'b000000, E_FETCH,  "dpi_fetch");
        add(1, 2'b00, 6'b000000, E_DECODE, "ldr_decode");
        // LDR
        add(1, 2'b01, 6'b000001, E_MEMADR, "ldr_memadr");
        add(1, 2'b00, 6'b000001, E_MEMRD,  "ldr_memrd");
        add(1, 2'b11, 6'b000000, E_MEMWB,  "ldr_memwb");
        add(1, 2'b11, 6'b000000, E_FETCH,  "ldr_fetch");
        add(1, 2'b00, 6'b111111, E_DECODE, "str_decode");
        // STR then B
        add(1, 2'b01, 6'b111110, E_MEMADR, "str_memadr");
        add(1, 2'b10, 6'b111110, E_MEMWR,  "str_memwr");
        add(1, 2'b10, 6'b000000, E_FETCH,  "str_fetch");
        add(1, 2'b00, 6'b000000, E_DECODE, "b_decode");
        add(1, 2'b10, 6'b000000, E_BR,     "b_branch");
        add(1, 2'b00, 6'b000000, E_FETCH,  "b_fetch");
        add(1, 2'b00, 6'b000000, E_DECODE, "ill_decode");
        add(1, 2'b11, 6'b000000, E_UNK,    "ill_unknown");

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].op, vecs[i].funct, vecs[i].exp, vecs[i].name);
        end

        // InstrDone gaps: DP->DPI 4, DPI->LDR 5, LDR->STR 4, STR->B 3
        check("done_count", done_at.size(), 5);
        if (done_at.size() == 5) begin
            check("gap_dp_dpi",  done_at[1] - done_at[0], 4);
            check("gap_dpi_ldr", done_at[2] - done_at[1], 5);
            check("gap_ldr_str", done_at[3] - done_at[2], 4);
            check("gap_str_b",   done_at[4] - done_at[3], 3);
        end

        // UNKNOWN sticks regardless of Op/Funct
        for (int i = 0; i < 12; i++) begin
            step(1, 2'(i), 6'(i * 7), E_UNK, "ill_hold");
        end
        step(0, 2'b11, 6'b000000, E_FETCH,  "ill_reset_fetch");
        step(1, 2'b01, 6'b000001, E_DECODE, "ill_release_decode");

        // Reset while in MEMRD abandons the load
        step(1, 2'b01, 6'b000001, E_MEMADR, "mid_memadr");
        step(1, 2'b01, 6'b000001, E_MEMRD,  "mid_memrd");
        step(0, 2'b01, 6'b000001, E_FETCH,  "mid_reset_fetch");
        step(1, 2'b01, 6'b000001, E_DECODE, "mid_decode");
        step(1, 2'b10, 6'b000001, E_BR,     "mid_branch_after");
        step(1, 2'b00, 6'b000000, E_FETCH,  "mid_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
